// File: rtl/transmissor_pkg.sv
// Shared state encodings and frame constants for the quadrant serial transmitter.
package transmissor_pkg;

  typedef enum logic [3:0] {
    INICIAL          = 4'd0,
    ENVIA_CABECALHO  = 4'd1,
    ESPERA_CABECALHO = 4'd2,
    LE_MEMORIA       = 4'd3,
    ESPERA_MEMORIA   = 4'd4,
    ENVIA_BYTE       = 4'd5,
    ESPERA_BYTE      = 4'd6,
    ATUALIZA         = 4'd7,
    ENVIA_CHECKSUM   = 4'd8,
    ESPERA_CHECKSUM  = 4'd9,
    FIM              = 4'd10
  } estado_t;

  localparam logic [7:0] CABECALHO_PADRAO = 8'hAA;
  localparam int         BITS_POR_QUADRO  = 10;

endpackage

// File: rtl/uart_tx_8n1.sv
// UART 8N1 transmitter: start bit, 8 data bits LSB first, stop bit.
module uart_tx_8n1
  import transmissor_pkg::*;
#(
  parameter int CLKS_POR_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [7:0] dado,
  output logic       saida_serial,
  output logic       ocupado,
  output logic       fim_transmissao
);

  localparam int CW = (CLKS_POR_BIT > 1) ? $clog2(CLKS_POR_BIT) : 1;

  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic [7:0]    dado_q;
  logic          saida_q;
  logic          ocupado_q;
  logic          fim_bit;
  logic          ultimo_bit;

  assign fim_bit    = (cnt_q == CW'(CLKS_POR_BIT - 1));
  assign ultimo_bit = (bit_q == 4'(BITS_POR_QUADRO - 1));

  // bit_q: 0 = start, 1..8 = data, 9 = stop; saida_q already holds the bit being sent
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      saida_q   <= 1'b1;
      ocupado_q <= 1'b0;
      cnt_q     <= '0;
      bit_q     <= '0;
      dado_q    <= '0;
    end else if (!ocupado_q) begin
      if (partida) begin
        dado_q    <= dado;
        saida_q   <= 1'b0;
        ocupado_q <= 1'b1;
        cnt_q     <= '0;
        bit_q     <= '0;
      end
    end else if (fim_bit) begin
      cnt_q <= '0;
      if (ultimo_bit) begin
        ocupado_q <= 1'b0;
        saida_q   <= 1'b1;
      end else begin
        bit_q   <= bit_q + 4'd1;
        saida_q <= (bit_q < 4'd8) ? dado_q[bit_q[2:0]] : 1'b1;
      end
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign saida_serial    = saida_q;
  assign ocupado         = ocupado_q;
  assign fim_transmissao = ocupado_q && fim_bit && ultimo_bit;

endmodule

// File: rtl/transmissor_quadrante_serial.sv
// Reads the 3x3 quadrant buffer and sends header, data bytes and XOR checksum over UART.
module transmissor_quadrante_serial
  import transmissor_pkg::*;
#(
  parameter int         CLKS_POR_BIT = 434,
  parameter int         LINHAS       = 3,
  parameter int         COLUNAS      = 3,
  parameter int         ADDR_W       = 4,
  parameter logic [7:0] CABECALHO    = CABECALHO_PADRAO
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [7:0]        dado_mem,
  output logic [ADDR_W-1:0] endereco_mem,
  output logic              le_mem,
  output logic              saida_serial,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int LW = (LINHAS > 1) ? $clog2(LINHAS) : 1;
  localparam int CW = (COLUNAS > 1) ? $clog2(COLUNAS) : 1;

  estado_t           estado_q;
  logic [LW-1:0]     linha_q;
  logic [CW-1:0]     coluna_q;
  logic [7:0]        checksum_q;
  logic [7:0]        dado_q;
  logic [ADDR_W-1:0] endereco_q;
  logic              le_mem_q;
  logic              ocupado_q;
  logic              pronto_q;

  logic              partida;
  logic [7:0]        byte_tx;
  logic              fim_transmissao;
  logic              ultima_coluna;
  logic              ultima_linha;

  function automatic logic [ADDR_W-1:0] calc_endereco(input logic [LW-1:0] l,
                                                      input logic [CW-1:0] c);
    return ADDR_W'(int'(l) * COLUNAS + int'(c));
  endfunction

  assign ultima_coluna = (coluna_q == CW'(COLUNAS - 1));
  assign ultima_linha  = (linha_q == LW'(LINHAS - 1));

  always_comb begin
    partida = 1'b0;
    byte_tx = 8'h00;
    case (estado_q)
      ENVIA_CABECALHO: begin partida = 1'b1; byte_tx = CABECALHO;  end
      ENVIA_BYTE:      begin partida = 1'b1; byte_tx = dado_q;     end
      ENVIA_CHECKSUM:  begin partida = 1'b1; byte_tx = checksum_q; end
      default: ;
    endcase
  end

  // le_mem/endereco are loaded on entry to LE_MEMORIA so they are valid during that state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= INICIAL;
      linha_q    <= '0;
      coluna_q   <= '0;
      checksum_q <= '0;
      endereco_q <= '0;
      le_mem_q   <= 1'b0;
      ocupado_q  <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      case (estado_q)
        INICIAL: begin
          pronto_q <= 1'b0;
          if (iniciar) begin
            ocupado_q  <= 1'b1;
            linha_q    <= '0;
            coluna_q   <= '0;
            checksum_q <= '0;
            estado_q   <= ENVIA_CABECALHO;
          end
        end
        ENVIA_CABECALHO: estado_q <= ESPERA_CABECALHO;
        ESPERA_CABECALHO: begin
          if (fim_transmissao) begin
            le_mem_q   <= 1'b1;
            endereco_q <= calc_endereco(linha_q, coluna_q);
            estado_q   <= LE_MEMORIA;
          end
        end
        LE_MEMORIA: begin
          le_mem_q <= 1'b0;
          estado_q <= ESPERA_MEMORIA;
        end
        ESPERA_MEMORIA: begin
          checksum_q <= checksum_q ^ dado_mem;
          estado_q   <= ENVIA_BYTE;
        end
        ENVIA_BYTE: estado_q <= ESPERA_BYTE;
        ESPERA_BYTE: if (fim_transmissao) estado_q <= ATUALIZA;
        ATUALIZA: begin
          if (ultima_coluna && ultima_linha) begin
            estado_q <= ENVIA_CHECKSUM;
          end else begin
            le_mem_q <= 1'b1;
            estado_q <= LE_MEMORIA;
            if (ultima_coluna) begin
              coluna_q   <= '0;
              linha_q    <= linha_q + LW'(1);
              endereco_q <= calc_endereco(linha_q + LW'(1), '0);
            end else begin
              coluna_q   <= coluna_q + CW'(1);
              endereco_q <= calc_endereco(linha_q, coluna_q + CW'(1));
            end
          end
        end
        ENVIA_CHECKSUM: estado_q <= ESPERA_CHECKSUM;
        ESPERA_CHECKSUM: if (fim_transmissao) estado_q <= FIM;
        FIM: begin
          pronto_q  <= 1'b1;
          ocupado_q <= 1'b0;
          estado_q  <= INICIAL;
        end
        default: estado_q <= INICIAL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (estado_q == ESPERA_MEMORIA) dado_q <= dado_mem;
  end

  uart_tx_8n1 #(
    .CLKS_POR_BIT(CLKS_POR_BIT)
  ) u_uart (
    .clock          (clock),
    .reset          (reset),
    .partida        (partida),
    .dado           (byte_tx),
    .saida_serial   (saida_serial),
    .ocupado        (),
    .fim_transmissao(fim_transmissao)
  );

  assign endereco_mem = endereco_q;
  assign le_mem       = le_mem_q;
  assign ocupado      = ocupado_q;
  assign pronto       = pronto_q;
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_transmissor_quadrante_serial.sv
// Bench for transmissor_quadrante_serial: UART decoder and address monitor fed by scoreboard queues.
module tb_transmissor_quadrante_serial;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [7:0] dado_mem = 8'h00;
  logic [3:0] endereco_mem;
  logic       le_mem;
  logic       saida_serial;
  logic       ocupado;
  logic       pronto;
  logic [3:0] db_estado;

  int n_checks = 0;
  int n_erros = 0;
  int n_prontos = 0;
  int n_bytes = 0;

  logic [7:0] fila_bytes[$];
  logic [3:0] fila_end[$];

  transmissor_quadrante_serial #(
    .CLKS_POR_BIT(CPB),
    .LINHAS      (3),
    .COLUNAS     (3),
    .ADDR_W      (4),
    .CABECALHO   (8'hAA)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .dado_mem    (dado_mem),
    .endereco_mem(endereco_mem),
    .le_mem      (le_mem),
    .saida_serial(saida_serial),
    .ocupado     (ocupado),
    .pronto      (pronto),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  // Memory model: one-cycle read latency, content = address + 1
  always @(posedge clock) begin
    if (le_mem) dado_mem <= 8'(endereco_mem) + 8'd1;
  end

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_erros++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  task automatic empilha_quadro();
    logic [7:0] cs;
    cs = 8'h00;
    fila_bytes.push_back(8'hAA);
    for (int i = 0; i < 9; i++) begin
      fila_bytes.push_back(8'(i + 1));
      fila_end.push_back(4'(i));
      cs = cs ^ 8'(i + 1);
    end
    fila_bytes.push_back(cs);
  endtask

  task automatic espera_pronto(input int limite);
    int ciclos;
    ciclos = 0;
    while (ciclos < limite && pronto !== 1'b1) begin
      @(negedge clock);
      ciclos++;
    end
    verifica("pronto_timeout", 32'(pronto), 1);
  endtask

  task automatic pulsa_iniciar();
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  // UART decoder, strobe monitor and pronto counter, sampled on the falling edge
  initial begin
    logic       amostras [0:39];
    logic [7:0] valor;
    logic       largura_ok;
    int         cnt;
    bit         ativo;
    ativo = 0;
    cnt = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        ativo = 0;
      end else begin
        if (pronto) n_prontos++;
        if (le_mem) begin
          verifica("le_estado", 32'(db_estado), 3);
          if (fila_end.size() == 0) verifica("le_extra", 32'(fila_end.size()), 1);
          else verifica("endereco", 32'(endereco_mem), 32'(fila_end.pop_front()));
        end
        if (!ativo) begin
          if (saida_serial == 1'b0) begin
            ativo = 1;
            amostras[0] = 1'b0;
            cnt = 1;
          end
        end else begin
          amostras[cnt] = saida_serial;
          cnt++;
          if (cnt == 10 * CPB) begin
            ativo = 0;
            largura_ok = 1'b1;
            for (int b = 0; b < 10; b++)
              for (int k = 1; k < CPB; k++)
                if (amostras[b*CPB + k] !== amostras[b*CPB]) largura_ok = 1'b0;
            for (int i = 0; i < 8; i++) valor[i] = amostras[(i + 1) * CPB];
            verifica("largura_bit", 32'(largura_ok), 1);
            verifica("stop_bit", 32'(amostras[9*CPB]), 1);
            n_bytes++;
            if (fila_bytes.size() == 0) verifica("byte_extra", 32'(fila_bytes.size()), 1);
            else verifica("byte", 32'(valor), 32'(fila_bytes.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int b0;
    int espera;

    // Reset and idle
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (50) @(negedge clock);
    verifica("idle_serial", 32'(saida_serial), 1);
    verifica("idle_ocupado", 32'(ocupado), 0);
    verifica("idle_pronto", 32'(pronto), 0);
    verifica("idle_estado", 32'(db_estado), 0);
    verifica("idle_le_mem", 32'(le_mem), 0);
    verifica("idle_endereco", 32'(endereco_mem), 0);

    // Single frame
    empilha_quadro();
    p0 = n_prontos;
    pulsa_iniciar();
    verifica("ocupado_inicio", 32'(ocupado), 1);
    verifica("estado_cabecalho", 32'(db_estado), 1);
    espera_pronto(1500);
    verifica("estado_pos_fim", 32'(db_estado), 0);
    verifica("ocupado_pos_fim", 32'(ocupado), 0);
    verifica("fila_bytes_q1", 32'(fila_bytes.size()), 0);
    verifica("fila_end_q1", 32'(fila_end.size()), 0);
    @(negedge clock);
    verifica("pronto_largura", 32'(pronto), 0);
    repeat (50) @(negedge clock);
    verifica("prontos_q1", 32'(n_prontos - p0), 1);
    verifica("serial_idle_q1", 32'(saida_serial), 1);

    // iniciar repeated mid-frame is ignored
    empilha_quadro();
    p0 = n_prontos;
    pulsa_iniciar();
    for (int i = 0; i < 14; i++) begin
      repeat (30) @(negedge clock);
      pulsa_iniciar();
    end
    verifica("ocupado_meio", 32'(ocupado), 1);
    espera_pronto(1500);
    repeat (100) @(negedge clock);
    verifica("prontos_q2", 32'(n_prontos - p0), 1);
    verifica("fila_bytes_q2", 32'(fila_bytes.size()), 0);
    verifica("fila_end_q2", 32'(fila_end.size()), 0);
    verifica("estado_q2", 32'(db_estado), 0);

    // Reset during the 4th data byte
    empilha_quadro();
    b0 = n_bytes;
    pulsa_iniciar();
    espera = 0;
    while (n_bytes < b0 + 4 && espera < 1000) begin
      @(negedge clock);
      espera++;
    end
    verifica("bytes_antes_reset", 32'(n_bytes - b0), 4);
    repeat (20) @(negedge clock);
    verifica("serial_antes_reset", 32'(ocupado), 1);
    #1 reset = 1'b1;
    #1;
    verifica("reset_serial", 32'(saida_serial), 1);
    verifica("reset_ocupado", 32'(ocupado), 0);
    verifica("reset_estado", 32'(db_estado), 0);
    verifica("reset_le_mem", 32'(le_mem), 0);
    repeat (2) @(negedge clock);
    fila_bytes.delete();
    fila_end.delete();
    p0 = n_prontos;
    b0 = n_bytes;
    reset = 1'b0;
    repeat (200) @(negedge clock);
    verifica("reset_sem_pronto", 32'(n_prontos - p0), 0);
    verifica("reset_sem_bytes", 32'(n_bytes - b0), 0);
    verifica("reset_serial_idle", 32'(saida_serial), 1);

    // Full frame after the aborted one
    empilha_quadro();
    p0 = n_prontos;
    pulsa_iniciar();
    espera_pronto(1500);
    repeat (20) @(negedge clock);
    verifica("prontos_q4", 32'(n_prontos - p0), 1);
    verifica("fila_bytes_q4", 32'(fila_bytes.size()), 0);
    verifica("fila_end_q4", 32'(fila_end.size()), 0);

    // iniciar held high: two back-to-back frames
    empilha_quadro();
    empilha_quadro();
    p0 = n_prontos;
    b0 = n_bytes;
    iniciar = 1'b1;
    @(negedge clock);
    espera_pronto(1500);
    verifica("b2b_ocupado_baixo", 32'(ocupado), 0);
    @(negedge clock);
    verifica("b2b_ocupado_volta", 32'(ocupado), 1);
    verifica("b2b_estado", 32'(db_estado), 1);
    espera_pronto(1500);
    iniciar = 1'b0;
    repeat (600) @(negedge clock);
    verifica("b2b_prontos", 32'(n_prontos - p0), 2);
    verifica("b2b_bytes", 32'(n_bytes - b0), 22);
    verifica("fila_bytes_b2b", 32'(fila_bytes.size()), 0);
    verifica("fila_end_b2b", 32'(fila_end.size()), 0);
    verifica("b2b_idle", 32'(db_estado), 0);

    $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
    $finish;
  end

endmodule

// File: doc/transmissor_quadrante_serial.md
Name: transmissor_quadrante_serial

Overview:
- Reads the 3x3 quadrant byte buffer filled by the OV7670 capture path and sends it to the host over UART 8N1.
- Frame: header byte, LINHAS*COLUNAS data bytes in row-major order, then an XOR checksum byte.
- This is the reader/transmitter counterpart of the capture-side writer.
- Contains its own control FSM plus one UART transmitter sub-module.

Parameters:
- CLKS_POR_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud).
- LINHAS, 3, quadrant rows.
- COLUNAS, 3, quadrant columns.
- ADDR_W, 4, memory address width; must satisfy 2^ADDR_W >= LINHAS*COLUNAS.
- CABECALHO, 8'hAA, frame header byte.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- iniciar  in  1  start request; sampled only in state inicial.
- dado_mem  in  8  memory read data, valid 1 cycle after le_mem.
- endereco_mem  out  ADDR_W  memory read address.
- le_mem  out  1  memory read strobe.
- saida_serial  out  1  UART TX line; idles high.
- ocupado  out  1  high from the cycle after iniciar is accepted until pronto.
- pronto  out  1  one-cycle pulse after the stop bit of the checksum byte.
- db_estado  out  4  current FSM state code, for debug.

Behaviour:
- Reset values (asynchronous): saida_serial=1, ocupado=0, pronto=0, le_mem=0, endereco_mem=0, db_estado=0, checksum=0, row/column counters=0, UART idle.
- Reset during a frame aborts it immediately. The line returns high with no partial stop bit, and no pronto is issued.
- UART sub-module:
  - Accepts partida only when idle; partida while busy is ignored.
  - Bit order: start 0, then d0..d7 (LSB first), then stop 1. Each bit lasts exactly CLKS_POR_BIT cycles, so one byte takes 10*CLKS_POR_BIT cycles.
  - The data byte is latched on partida.
  - fim_transmissao pulses for 1 cycle in the last cycle of the stop bit.
- FSM states and codes:
  - inicial (0): iniciar=1 -> envia_cabecalho; counters zeroed; checksum zeroed.
  - envia_cabecalho (1): partida with CABECALHO -> espera_cabecalho.
  - espera_cabecalho (2): on fim_transmissao -> le_memoria.
  - le_memoria (3): le_mem=1, endereco_mem=linha*COLUNAS+coluna -> espera_memoria.
  - espera_memoria (4): latch dado_mem; checksum ^= dado_mem -> envia_byte.
  - envia_byte (5): partida with the latched byte -> espera_byte.
  - espera_byte (6): on fim_transmissao -> atualiza.
  - atualiza (7):
    - If last column and last row -> envia_checksum.
    - Else if last column: coluna=0, linha+1 -> le_memoria.
    - Else coluna+1 -> le_memoria.
  - envia_checksum (8): partida with checksum -> espera_checksum.
  - espera_checksum (9): on fim_transmissao -> fim.
  - fim (10): pronto=1 -> inicial.
  - Unused codes -> inicial.
- endereco_mem holds its value outside le_memoria. Memory read latency is exactly 1 cycle.
- iniciar in any state other than inicial is ignored. No request is queued.
- If iniciar stays high in inicial immediately after fim, a new frame starts at once. Back-to-back frames are allowed.
- Data checksum is the XOR of data bytes only; the header is excluded.
- Counter widths are $clog2 of the dimension, minimum 1 bit.

Decomposition:
- Package transmissor_pkg: FSM state encodings (4-bit), CABECALHO default, bits-per-frame constant (10).
- Sub-module uart_tx_8n1 with ports:
  - clock, reset, partida, dado[7:0]
  - saida_serial, ocupado, fim_transmissao
  - parameter CLKS_POR_BIT
- The control FSM, counters and checksum stay in the top module.

Test Plan (CLKS_POR_BIT=4 in simulation; memory model returns address+1):
- Reset then idle 50 cycles -> saida_serial=1, ocupado=0, pronto=0, db_estado=0.
- Pulse iniciar -> serial bytes decode as AA,01,02,...,09,01. The checksum is 01 (XOR of 1..9). pronto pulses once, ~440 cycles after start. Each bit is exactly 4 cycles wide and LSB first.
- Observe le_mem -> exactly 9 strobes, addresses 0..8 in order, each followed one cycle later by the byte latch.
- Assert iniciar repeatedly mid-frame -> the frame is unchanged and exactly one pronto is issued.
- Assert reset during the 4th data byte -> saida_serial=1 immediately, no pronto. A subsequent iniciar sends a complete, correct frame starting with AA.
- Hold iniciar high continuously -> two consecutive identical frames, with pronto between them and ocupado low for exactly one cycle (inicial).
